// File: rtl/iot_mon_pkg.sv
// Shared constants and helpers for the multi-channel IoT device monitor.
package iot_mon_pkg;

  // Counter boundary behaviour: wrap modulo 2^WIDTH or clamp at 0 / max
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2 that never returns less than 1, so a select port always has a bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iot_chan_counter.sv
// One device-group channel: up/down counter with wrap or clamp at the ends,
// boundary-event detect, and a high/low water-mark hysteresis alarm.
// The next-state count is exported so the parent can build an exact total.
module iot_chan_counter
  import iot_mon_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = MODE_WRAP,
  parameter int HIGH_WM  = 200,
  parameter int LOW_WM   = 180
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change,
  input  logic             on_off,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             bnd_event,
  output logic             alarm
);

  localparam logic [WIDTH-1:0] MAX_CNT = '1;

  logic at_max;
  logic at_min;
  logic alarm_next;

  // Next count: a step past either end is a boundary event; in clamp mode it
  // holds the counter, in wrap mode modular arithmetic does the wrapping.
  always_comb begin
    at_max     = (count == MAX_CNT);
    at_min     = (count == '0);
    bnd_event  = change & (on_off ? at_max : at_min);
    next_count = count;
    if (change) begin
      if (bnd_event && (SATURATE == MODE_SAT)) begin
        next_count = count;
      end else if (on_off) begin
        next_count = count + WIDTH'(1);
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

  // Hysteresis judged on the next-state count, so a wrap to 0 drops the alarm at once
  always_comb begin
    alarm_next = alarm;
    if (!alarm && (int'(next_count) >= HIGH_WM)) begin
      alarm_next = 1'b1;
    end else if (alarm && (int'(next_count) < LOW_WM)) begin
      alarm_next = 1'b0;
    end
  end

  // Counter and alarm registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      alarm <= 1'b0;
    end else begin
      count <= next_count;
      alarm <= alarm_next;
    end
  end

endmodule

// File: rtl/iot_monitor_mc.sv
// Multi-channel active-device monitor: N_CH independent channel counters, an
// exact registered total across channels, sticky boundary flags and a readback mux.
module iot_monitor_mc
  import iot_mon_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = MODE_WRAP,
  parameter int HIGH_WM  = 200,
  parameter int LOW_WM   = 180,
  localparam int SEL_W   = clog2_min1(N_CH),
  localparam int TOT_W   = WIDTH + SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  change,
  input  logic [N_CH-1:0]  on_off,
  input  logic             clr_flags,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_count,
  output logic [TOT_W-1:0] total,
  output logic [N_CH-1:0]  alarm,
  output logic [N_CH-1:0]  bnd_flag
);

  logic [N_CH-1:0][WIDTH-1:0] cnt;
  logic [N_CH-1:0][WIDTH-1:0] next_cnt;
  logic [N_CH-1:0]            bnd_vec;
  logic [TOT_W-1:0]           total_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    iot_chan_counter #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE),
      .HIGH_WM  (HIGH_WM),
      .LOW_WM   (LOW_WM)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .change     (change[i]),
      .on_off     (on_off[i]),
      .count      (cnt[i]),
      .next_count (next_cnt[i]),
      .bnd_event  (bnd_vec[i]),
      .alarm      (alarm[i])
    );
  end

  // Sum of next-state counts; TOT_W has room for N_CH maximal channels
  always_comb begin
    total_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      total_next = total_next + TOT_W'(next_cnt[i]);
    end
  end

  // Registered total, in step with the channel counters it summarises
  always_ff @(posedge clk) begin
    if (rst) begin
      total <= '0;
    end else begin
      total <= total_next;
    end
  end

  // Sticky boundary flags; a new event in the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      bnd_flag <= '0;
    end else begin
      bnd_flag <= (clr_flags ? '0 : bnd_flag) | bnd_vec;
    end
  end

  // Readback mux; selects beyond the last channel read as zero
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_count = cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_iot_monitor_mc.sv
// Scoreboard bench for iot_monitor_mc: a wrapping 4-channel instance and a
// clamping 3-channel instance share stimulus; a plain-integer model predicts each cycle.
module tb_iot_monitor_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] change = '0;
  logic [3:0] on_off = '0;
  logic       clr_flags = 1'b0;
  logic [1:0] rd_sel = '0;

  logic [7:0] rd_w;
  logic [9:0] tot_w;
  logic [3:0] al_w;
  logic [3:0] fl_w;
  logic [7:0] rd_s;
  logic [9:0] tot_s;
  logic [2:0] al_s;
  logic [2:0] fl_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rd0; int tot0; int al0; int fl0;
    int rd1; int tot1; int al1; int fl1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Model state: index 0 = wrapping 4-channel DUT, 1 = clamping 3-channel DUT
  int mc [2][4];
  int mal[2][4];
  int mfl[2][4];

  always #5 clk = ~clk;

  iot_monitor_mc #(.N_CH(4), .WIDTH(8), .SATURATE(0), .HIGH_WM(200), .LOW_WM(180)) dut_wrap (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .clr_flags(clr_flags),
    .rd_sel(rd_sel), .rd_count(rd_w), .total(tot_w), .alarm(al_w), .bnd_flag(fl_w)
  );

  iot_monitor_mc #(.N_CH(3), .WIDTH(8), .SATURATE(1), .HIGH_WM(200), .LOW_WM(180)) dut_sat (
    .clk(clk), .rst(rst), .change(change[2:0]), .on_off(on_off[2:0]), .clr_flags(clr_flags),
    .rd_sel(rd_sel), .rd_count(rd_s), .total(tot_s), .alarm(al_s), .bnd_flag(fl_s)
  );

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs
  task automatic applyStimulus(input bit r, input logic [3:0] ch, input logic [3:0] oo,
                               input bit clr, input logic [1:0] sel);
    exp_t e;
    int   c;
    bit   bnd;
    int   tot, al, fl, rd;
    @(negedge clk);
    #1;
    rst = r; change = ch; on_off = oo; clr_flags = clr; rd_sel = sel;
    for (int d = 0; d < 2; d++) begin
      tot = 0; al = 0; fl = 0;
      for (int i = 0; i < nch(d); i++) begin
        if (r) begin
          mc[d][i] = 0; mal[d][i] = 0; mfl[d][i] = 0;
        end else begin
          c = mc[d][i];
          bnd = 1'b0;
          if (ch[i]) begin
            c = oo[i] ? c + 1 : c - 1;
            if (c > 255 || c < 0) begin
              bnd = 1'b1;
              c = (d == 1) ? mc[d][i] : (c + 256) % 256;
            end
          end
          mc[d][i] = c;
          if (mal[d][i] == 0 && c >= 200) mal[d][i] = 1;
          else if (mal[d][i] == 1 && c < 180) mal[d][i] = 0;
          mfl[d][i] = bnd ? 1 : (clr ? 0 : mfl[d][i]);
        end
        tot += mc[d][i];
        al  += mal[d][i] << i;
        fl  += mfl[d][i] << i;
      end
      rd = (int'(sel) < nch(d)) ? mc[d][sel] : 0;
      if (d == 0) begin e.rd0 = rd; e.tot0 = tot; e.al0 = al; e.fl0 = fl; end
      else        begin e.rd1 = rd; e.tot1 = tot; e.al1 = al; e.fl1 = fl; end
    end
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Monitor: every settled cycle with a pending expectation is compared
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("wrap.rd_count", int'(rd_w),  mon_e.rd0);
        checkOutput("wrap.total",    int'(tot_w), mon_e.tot0);
        checkOutput("wrap.alarm",    int'(al_w),  mon_e.al0);
        checkOutput("wrap.bnd_flag", int'(fl_w),  mon_e.fl0);
        checkOutput("sat.rd_count",  int'(rd_s),  mon_e.rd1);
        checkOutput("sat.total",     int'(tot_s), mon_e.tot1);
        checkOutput("sat.alarm",     int'(al_s),  mon_e.al1);
        checkOutput("sat.bnd_flag",  int'(fl_s),  mon_e.fl1);
      end
    end
  end

  // Watchdog so a stalled run still ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rch, roo;
    // Reset, then count channel 0 up ten times
    repeat (2) applyStimulus(1, 4'h0, 4'h0, 0, 2'd0);
    repeat (10) applyStimulus(0, 4'b0001, 4'b0001, 0, 2'd0);
    // Reset in the middle of counting
    repeat (3) applyStimulus(0, 4'hF, 4'hF, 0, 2'd1);
    applyStimulus(1, 4'hF, 4'hF, 1, 2'd1);
    // Preload to 5 then a simultaneous up/down mix
    repeat (5) applyStimulus(0, 4'hF, 4'hF, 0, 2'd2);
    applyStimulus(0, 4'hF, 4'b0101, 0, 2'd2);
    // Top boundary on channels 1 and 2, then step back down
    applyStimulus(1, 4'h0, 4'h0, 0, 2'd1);
    repeat (255) applyStimulus(0, 4'b0110, 4'b0110, 0, 2'd1);
    applyStimulus(0, 4'b0110, 4'b0110, 0, 2'd1);
    applyStimulus(0, 4'b0110, 4'b0110, 0, 2'd2);
    applyStimulus(0, 4'b0110, 4'b0000, 0, 2'd1);
    // Bottom boundary from zero
    applyStimulus(1, 4'h0, 4'h0, 0, 2'd2);
    applyStimulus(0, 4'b0110, 4'b0000, 0, 2'd2);
    // Flag clear, then clear racing a new boundary event on channel 0
    applyStimulus(0, 4'h0, 4'h0, 1, 2'd0);
    applyStimulus(0, 4'b0001, 4'b0000, 1, 2'd0);
    applyStimulus(0, 4'h0, 4'h0, 0, 2'd0);
    // Hysteresis on channel 3 (clamping instance reads select 3 as zero)
    applyStimulus(1, 4'h0, 4'h0, 0, 2'd3);
    repeat (199) applyStimulus(0, 4'b1000, 4'b1000, 0, 2'd3);
    applyStimulus(0, 4'b1000, 4'b1000, 0, 2'd3);
    repeat (20) applyStimulus(0, 4'b1000, 4'b0000, 0, 2'd3);
    applyStimulus(0, 4'b1000, 4'b0000, 0, 2'd3);
    repeat (20) applyStimulus(0, 4'b1000, 4'b1000, 0, 2'd3);
    // Random traffic, first half biased upward to reach the alarm region
    for (int n = 0; n < 1500; n++) begin
      rch = 4'($urandom);
      roo = (n < 750) ? 4'($urandom | $urandom) : 4'($urandom);
      applyStimulus(($urandom_range(199) == 0), rch, roo,
                    ($urandom_range(15) == 0), 2'($urandom));
    end
    // Drain the scoreboard
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iot_monitor_mc.md
Name: iot_monitor_mc

Overview:
Multi-channel monitor of active IoT devices. It keeps one up/down counter per device group, plus an exact aggregate total across all groups. Each channel raises a hysteresis high-water alarm and a sticky boundary-event flag. Each channel counter replaces the single 8-bit monitor counter. The block feeds the status/readback logic of the monitoring subsystem.

Parameters:
N_CH, 4, number of independent device-group channels (1..16)
WIDTH, 8, bits per channel counter
SATURATE, 0, 0 = counters wrap modulo 2^WIDTH; 1 = counters clamp at 0 and 2^WIDTH-1
HIGH_WM, 200, alarm asserts when a channel count >= HIGH_WM
LOW_WM, 180, alarm deasserts when a channel count < LOW_WM; LOW_WM <= HIGH_WM is required
SEL_W, max(1,clog2(N_CH)), derived, width of rd_sel
TOT_W, WIDTH+SEL_W, derived, width of total

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
change  in  N_CH  per-channel count enable; 0 holds the channel
on_off  in  N_CH  per-channel direction; 1 = up (device on), 0 = down (device off)
clr_flags  in  1  clears all sticky bnd_flag bits
rd_sel  in  SEL_W  channel select for rd_count
rd_count  out  WIDTH  counter of channel rd_sel, combinational mux of registered counters
total  out  TOT_W  registered sum of all channel counters
alarm  out  N_CH  registered per-channel high-water alarm
bnd_flag  out  N_CH  sticky per-channel boundary event (wrap or clamp)

Behaviour:
- Reset: when rst=1 at a posedge, all counters, total, alarm and bnd_flag are set to 0. rst has priority over all other inputs, including mid-count and during clr_flags.
- Per channel i, per posedge, with rst=0:
  - change[i]=0: counter holds.
  - change[i]=1, on_off[i]=1: counter increments by 1.
  - change[i]=1, on_off[i]=0: counter decrements by 1.
  - Latency is 1 cycle. Channels are fully independent, and any mix of simultaneous events is legal.
- Boundaries:
  - SATURATE=0: max+1 wraps to 0, and 0-1 wraps to max.
  - SATURATE=1: an up-count at max and a down-count at 0 leave the counter unchanged.
  - Either case is a boundary event.
- bnd_flag[i]: set on the posedge at which channel i has a boundary event. Cleared by clr_flags=1. If a set and a clear occur in the same cycle, set wins.
- total: at every cycle, total equals the exact unsigned sum of all channel counters after the same posedge. It is computed from next-state counter values and registered, so it is never one cycle stale. TOT_W guarantees the sum never overflows. Wraps in a channel are reflected exactly; for example, one channel going 255->0 lowers total by 255.
- alarm[i]: registered, evaluated on the next-state count c':
  - If alarm=0 and c' >= HIGH_WM: set.
  - If alarm=1 and c' < LOW_WM: clear.
  - Otherwise hold.
  - A wrap from max to 0 therefore clears the alarm in the same cycle.
- rd_count: rd_sel >= N_CH returns 0.
- No X propagation: all outputs are defined from the first post-reset cycle.

Decomposition:
- Package iot_mon_pkg holds:
  - mode constants MODE_WRAP=0 and MODE_SAT=1
  - a clog2-with-minimum-1 function used for SEL_W
- Sub-module iot_chan_counter, instantiated N_CH times, contains:
  - one WIDTH counter with its wrap/saturate logic
  - the boundary-event detect
  - the hysteresis alarm
  - a next-count output for the total adder
- The top level holds the total adder/register, the bnd_flag array and the rd_sel mux.

Test Plan:
- Reset and count. rst=1 for 2 cycles, then 10 cycles of change=4'b0001, on_off=4'b0001 -> ch0=10, total=10, other channels 0, alarm=0, bnd_flag=0. Assert rst mid-run -> all outputs 0 on the next posedge.
- Simultaneous mix. Preload ch0..ch3 = 5, then one cycle of change=4'b1111, on_off=4'b0101 -> ch0=6, ch1=4, ch2=6, ch3=4, total=20 (unchanged), rd_sel=2 -> rd_count=6.
- Wrap (SATURATE=0). ch1=255 with an up event -> ch1=0, bnd_flag[1]=1, total drops by 255. ch1=0 with a down event -> ch1=255.
- Saturate (SATURATE=1). ch2=255 with an up event -> stays 255 and bnd_flag[2]=1. 0 with a down event -> stays 0.
- Hysteresis. Count ch3 up to 199 -> alarm[3]=0; 200 -> alarm[3]=1. Count down to 180 -> still 1; 179 -> 0. Back up to 199 -> remains 0.
- Flag clear race. bnd_flag[0]=1 with clr_flags=1 -> cleared. Same cycle as a new wrap on ch0 -> bnd_flag[0] stays 1.
